// File: rtl/ddr_port_responder.sv
// ddr_port_responder
//
// Memory-side responder for the internal access interface used by the
// Wishbone port. Each access becomes one request on the DDR controller local
// (Avalon-MM) interface:
//   - writes are single-word, acknowledged once the controller accepts them;
//   - reads are line refills of 2^bw words, where bw = min(buf_width_i,
//     MAX_BUF_WIDTH). Every returned word is acknowledged with its own byte
//     address so the requester can fill its line buffer.
// Only one access is outstanding at a time. After the last ack the block waits
// for acc_i to drop before it accepts another access.
//
// Ports
//   sdram_clk, sdram_rst_n    clock, asynchronous active-low reset
//   acc_i, we_i, adr_i,       access request from the requester; these are
//   dat_i, sel_i,             sampled only in IDLE
//   buf_width_i
//   ack_o, adr_o, dat_o       per-word acknowledge, byte address and read data
//   avl_*                     DDR controller local interface
// All outputs are registered and are 0 while in reset.

module ddr_port_responder #(
   parameter int unsigned AVL_ADDR_WIDTH = 24,
   parameter int unsigned MAX_BUF_WIDTH  = 4
) (
   input  logic                      sdram_clk,
   input  logic                      sdram_rst_n,

   input  logic                      acc_i,
   input  logic                      we_i,
   input  logic [31:0]               adr_i,
   input  logic [31:0]               dat_i,
   input  logic [3:0]                sel_i,
   input  logic [3:0]                buf_width_i,
   output logic                      ack_o,
   output logic [31:0]               adr_o,
   output logic [31:0]               dat_o,

   output logic [AVL_ADDR_WIDTH-1:0] avl_address,
   output logic                      avl_burstbegin,
   output logic                      avl_read_req,
   output logic                      avl_write_req,
   output logic [MAX_BUF_WIDTH:0]    avl_size,
   output logic [31:0]               avl_wdata,
   output logic [3:0]                avl_be,
   input  logic                      avl_ready,
   input  logic [31:0]               avl_rdata,
   input  logic                      avl_rdata_valid
);

   localparam int unsigned BwW   = $clog2(MAX_BUF_WIDTH + 1);
   localparam int unsigned SizeW = MAX_BUF_WIDTH + 1;

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StRdReq,
      StRdData,
      StRelease
   } state_e;

   state_e                     state_q, state_d;
   // Word-aligned write address, or line base for reads.
   logic [31:0]                adr_q, adr_d;
   logic [BwW-1:0]             bw_q, bw_d;
   logic [MAX_BUF_WIDTH-1:0]   idx_q, idx_d;

   logic                       ack_q, ack_d;
   logic [31:0]                adr_o_q, adr_o_d;
   logic [31:0]                dat_o_q, dat_o_d;
   logic [AVL_ADDR_WIDTH-1:0]  avl_address_q, avl_address_d;
   logic                       avl_burstbegin_q, avl_burstbegin_d;
   logic                       avl_read_req_q, avl_read_req_d;
   logic                       avl_write_req_q, avl_write_req_d;
   logic [SizeW-1:0]           avl_size_q, avl_size_d;
   logic [31:0]                avl_wdata_q, avl_wdata_d;
   logic [3:0]                 avl_be_q, avl_be_d;

   // Values derived from the incoming access, used only when leaving IDLE.
   logic [BwW-1:0]             bw_in;
   logic [SizeW-1:0]           size_in;
   logic [31:0]                line_mask_in;
   logic [31:0]                rd_base_in;

   // Index of the final word of the current line.
   logic [SizeW-1:0]           words_q;
   logic [MAX_BUF_WIDTH-1:0]   last_idx;

   always_comb begin
      bw_in        = '0;
      size_in      = '0;
      line_mask_in = '0;
      rd_base_in   = '0;

      if (buf_width_i > 4'(MAX_BUF_WIDTH)) begin
         bw_in = BwW'(MAX_BUF_WIDTH);
      end else begin
         bw_in = BwW'(buf_width_i);
      end
      size_in      = SizeW'(1) << bw_in;
      // Byte-offset mask of one line: 2^bw words of 4 bytes each.
      line_mask_in = (32'(size_in) << 2) - 32'd1;
      rd_base_in   = adr_i & ~line_mask_in;
   end

   always_comb begin
      words_q  = SizeW'(1) << bw_q;
      // For bw = MAX_BUF_WIDTH the low bits are zero and this wraps to all ones.
      last_idx = words_q[MAX_BUF_WIDTH-1:0] - MAX_BUF_WIDTH'(1);
   end

   always_comb begin
      state_d          = state_q;
      adr_d            = adr_q;
      bw_d             = bw_q;
      idx_d            = idx_q;

      ack_d            = 1'b0;
      adr_o_d          = adr_o_q;
      dat_o_d          = dat_o_q;
      avl_address_d    = avl_address_q;
      avl_burstbegin_d = avl_burstbegin_q;
      avl_read_req_d   = avl_read_req_q;
      avl_write_req_d  = avl_write_req_q;
      avl_size_d       = avl_size_q;
      avl_wdata_d      = avl_wdata_q;
      avl_be_d         = avl_be_q;

      unique case (state_q)
         StIdle: begin
            if (acc_i) begin
               bw_d             = bw_in;
               avl_burstbegin_d = 1'b1;
               if (we_i) begin
                  adr_d           = {adr_i[31:2], 2'b00};
                  avl_write_req_d = 1'b1;
                  avl_size_d      = SizeW'(1);
                  avl_address_d   = adr_i[AVL_ADDR_WIDTH+1:2];
                  avl_wdata_d     = dat_i;
                  avl_be_d        = sel_i;
                  state_d         = StWrReq;
               end else begin
                  adr_d           = rd_base_in;
                  avl_read_req_d  = 1'b1;
                  avl_size_d      = size_in;
                  avl_address_d   = rd_base_in[AVL_ADDR_WIDTH+1:2];
                  state_d         = StRdReq;
               end
            end
         end

         StWrReq: begin
            // Request is held with stable values until the controller takes it.
            if (avl_ready) begin
               avl_write_req_d  = 1'b0;
               avl_burstbegin_d = 1'b0;
               avl_address_d    = '0;
               avl_size_d       = '0;
               avl_wdata_d      = '0;
               avl_be_d         = '0;
               ack_d            = 1'b1;
               adr_o_d          = adr_q;
               state_d          = StRelease;
            end
         end

         StRdReq: begin
            if (avl_ready) begin
               avl_read_req_d   = 1'b0;
               avl_burstbegin_d = 1'b0;
               avl_address_d    = '0;
               avl_size_d       = '0;
               idx_d            = '0;
               state_d          = StRdData;
            end
         end

         StRdData: begin
            if (avl_rdata_valid) begin
               ack_d   = 1'b1;
               dat_o_d = avl_rdata;
               adr_o_d = adr_q + (32'(idx_q) << 2);
               idx_d   = idx_q + MAX_BUF_WIDTH'(1);
               if (idx_q == last_idx) begin
                  state_d = StRelease;
               end
            end
         end

         StRelease: begin
            // A still-high acc_i belongs to the access just finished.
            if (!acc_i) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         state_q          <= StIdle;
         adr_q            <= '0;
         bw_q             <= '0;
         idx_q            <= '0;
         ack_q            <= 1'b0;
         adr_o_q          <= '0;
         dat_o_q          <= '0;
         avl_address_q    <= '0;
         avl_burstbegin_q <= 1'b0;
         avl_read_req_q   <= 1'b0;
         avl_write_req_q  <= 1'b0;
         avl_size_q       <= '0;
         avl_wdata_q      <= '0;
         avl_be_q         <= '0;
      end else begin
         state_q          <= state_d;
         adr_q            <= adr_d;
         bw_q             <= bw_d;
         idx_q            <= idx_d;
         ack_q            <= ack_d;
         adr_o_q          <= adr_o_d;
         dat_o_q          <= dat_o_d;
         avl_address_q    <= avl_address_d;
         avl_burstbegin_q <= avl_burstbegin_d;
         avl_read_req_q   <= avl_read_req_d;
         avl_write_req_q  <= avl_write_req_d;
         avl_size_q       <= avl_size_d;
         avl_wdata_q      <= avl_wdata_d;
         avl_be_q         <= avl_be_d;
      end
   end

   assign ack_o          = ack_q;
   assign adr_o          = adr_o_q;
   assign dat_o          = dat_o_q;
   assign avl_address    = avl_address_q;
   assign avl_burstbegin = avl_burstbegin_q;
   assign avl_read_req   = avl_read_req_q;
   assign avl_write_req  = avl_write_req_q;
   assign avl_size       = avl_size_q;
   assign avl_wdata      = avl_wdata_q;
   assign avl_be         = avl_be_q;

endmodule

// File: tb/tb_ddr_port_responder.sv
// Testbench for ddr_port_responder: table of accesses applied in a loop, a
// scoreboard queue of expected acks checked by an ack monitor, and hand-written
// sequences for spurious read data and reset in the middle of a burst.

module tb_ddr_port_responder;

   logic        sdram_clk       = 1'b0;
   logic        sdram_rst_n     = 1'b0;
   logic        acc_i           = 1'b0;
   logic        we_i            = 1'b0;
   logic [31:0] adr_i           = '0;
   logic [31:0] dat_i           = '0;
   logic [3:0]  sel_i           = '0;
   logic [3:0]  buf_width_i     = '0;
   logic        ack_o;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [23:0] avl_address;
   logic        avl_burstbegin;
   logic        avl_read_req;
   logic        avl_write_req;
   logic [4:0]  avl_size;
   logic [31:0] avl_wdata;
   logic [3:0]  avl_be;
   logic        avl_ready       = 1'b0;
   logic [31:0] avl_rdata       = '0;
   logic        avl_rdata_valid = 1'b0;

   ddr_port_responder #(
      .AVL_ADDR_WIDTH (24),
      .MAX_BUF_WIDTH  (4)
   ) dut (
      .sdram_clk       (sdram_clk),
      .sdram_rst_n     (sdram_rst_n),
      .acc_i           (acc_i),
      .we_i            (we_i),
      .adr_i           (adr_i),
      .dat_i           (dat_i),
      .sel_i           (sel_i),
      .buf_width_i     (buf_width_i),
      .ack_o           (ack_o),
      .adr_o           (adr_o),
      .dat_o           (dat_o),
      .avl_address     (avl_address),
      .avl_burstbegin  (avl_burstbegin),
      .avl_read_req    (avl_read_req),
      .avl_write_req   (avl_write_req),
      .avl_size        (avl_size),
      .avl_wdata       (avl_wdata),
      .avl_be          (avl_be),
      .avl_ready       (avl_ready),
      .avl_rdata       (avl_rdata),
      .avl_rdata_valid (avl_rdata_valid)
   );

   always #5 sdram_clk = ~sdram_clk;

   int checks  = 0;
   int errors  = 0;
   int ack_cnt = 0;
   int cyc     = 0;

   typedef struct {
      int          due;
      logic [31:0] adr;
      logic [31:0] dat;
      bit          chk_dat;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [3:0]  bw;
      int          stall;
      int          gap_at;
      logic [31:0] exp_addr;
      logic [31:0] exp_size;
      int          n_words;
      logic [31:0] base;
   } tvec_t;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check32({tag, "_ack"}, 32'(ack_o), 32'h0);
      check32({tag, "_adr_o"}, adr_o, 32'h0);
      check32({tag, "_dat_o"}, dat_o, 32'h0);
      check32({tag, "_avl_address"}, 32'(avl_address), 32'h0);
      check32({tag, "_flags"}, 32'({avl_burstbegin, avl_read_req, avl_write_req}), 32'h0);
      check32({tag, "_avl_size"}, 32'(avl_size), 32'h0);
      check32({tag, "_avl_wdata"}, avl_wdata, 32'h0);
      check32({tag, "_avl_be"}, 32'(avl_be), 32'h0);
   endtask

   // Cycle counter, advanced on the active edge.
   initial begin
      forever begin
         @(posedge sdram_clk);
         cyc++;
      end
   end

   // Ack monitor: every ack must match the oldest expected entry, in its cycle.
   initial begin
      forever begin
         @(negedge sdram_clk);
         if (ack_o === 1'b1) begin
            ack_cnt++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: ack_o 1 with adr_o %h, required no ack", adr_o);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check32("ack_cycle", 32'(cyc), 32'(e.due));
               check32("ack_adr", adr_o, e.adr);
               if (e.chk_dat) check32("ack_dat", dat_o, e.dat);
            end
         end
      end
   end

   task automatic wait_req(input bit rd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if ((rd ? avl_read_req : avl_write_req) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge sdram_clk);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL req_timeout: no %s request within 20 cycles", rd ? "read" : "write");
      end
   endtask

   task automatic check_req(input tvec_t v, input int id);
      check32($sformatf("v%0d_address", id), 32'(avl_address), v.exp_addr);
      check32($sformatf("v%0d_size", id), 32'(avl_size), v.exp_size);
      check32($sformatf("v%0d_burstbegin", id), 32'(avl_burstbegin), 32'h1);
      check32($sformatf("v%0d_req", id), 32'({avl_read_req, avl_write_req}),
              v.we ? 32'h1 : 32'h2);
      if (v.we) begin
         check32($sformatf("v%0d_wdata", id), avl_wdata, v.dat);
         check32($sformatf("v%0d_be", id), 32'(avl_be), 32'(v.sel));
      end
   endtask

   task automatic start_access(input tvec_t v);
      @(negedge sdram_clk);
      acc_i       = 1'b1;
      we_i        = v.we;
      adr_i       = v.adr;
      dat_i       = v.dat;
      sel_i       = v.sel;
      buf_width_i = v.bw;
   endtask

   task automatic run_vec(input tvec_t v, input int id);
      bit ok;
      int ack0;
      ack0 = ack_cnt;
      start_access(v);
      wait_req(!v.we, ok);
      if (ok) begin
         // Inputs changing after the access is taken must have no effect.
         we_i        = ~v.we;
         adr_i       = ~v.adr;
         dat_i       = 32'h0;
         sel_i       = 4'h0;
         buf_width_i = 4'h0;
         for (int s = 0; s < v.stall; s++) begin
            check_req(v, id);
            @(negedge sdram_clk);
         end
         check_req(v, id);
         avl_ready = 1'b1;
         if (v.we) sb.push_back('{cyc + 1, v.base, 32'h0, 1'b0});
         @(negedge sdram_clk);
         avl_ready = 1'b0;
         check32($sformatf("v%0d_req_drop", id), 32'({avl_read_req, avl_write_req}), 32'h0);
         if (!v.we) begin
            for (int i = 0; i < v.n_words; i++) begin
               if (i == v.gap_at) begin
                  avl_rdata_valid = 1'b0;
                  repeat (2) @(negedge sdram_clk);
               end
               avl_rdata_valid = 1'b1;
               avl_rdata       = v.dat + 32'(i);
               sb.push_back('{cyc + 1, v.base + 32'(4 * i), v.dat + 32'(i), 1'b1});
               @(negedge sdram_clk);
            end
            avl_rdata_valid = 1'b0;
         end
         // acc_i still high: no new request may start.
         repeat (3) begin
            check32($sformatf("v%0d_release_noreq", id),
                    32'({avl_read_req, avl_write_req}), 32'h0);
            @(negedge sdram_clk);
         end
      end
      check32($sformatf("v%0d_ack_count", id), 32'(ack_cnt - ack0), 32'(v.n_words));
      check32($sformatf("v%0d_sb_empty", id), 32'(sb.size()), 32'h0);
      sb.delete();
      acc_i = 1'b0;
      we_i  = 1'b0;
      adr_i = '0;
      repeat (2) @(negedge sdram_clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tvec_t vecs[7];
      tvec_t rv;
      bit    ok;
      int    ack0;

      //          we    adr            dat            sel   bw    stall gap  addr            size   n   base
      vecs[0] = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'h6, 4'd0, 0,    -1,  32'h0000_048D, 32'd1,  1, 32'h0000_1234};
      vecs[1] = '{1'b1, 32'h0000_ABC8, 32'h1234_5678, 4'hF, 4'd0, 5,    -1,  32'h0000_2AF2, 32'd1,  1, 32'h0000_ABC8};
      vecs[2] = '{1'b0, 32'h0000_0054, 32'h0000_0100, 4'h0, 4'd3, 0,    4,   32'h0000_0010, 32'd8,  8, 32'h0000_0040};
      vecs[3] = '{1'b0, 32'h0123_4568, 32'h0000_0200, 4'h0, 4'd7, 1,    -1,  32'h0048_D150, 32'd16, 16, 32'h0123_4540};
      vecs[4] = '{1'b0, 32'h0000_0008, 32'h0000_0300, 4'h0, 4'd0, 0,    -1,  32'h0000_0002, 32'd1,  1, 32'h0000_0008};
      vecs[5] = '{1'b0, 32'hF000_0010, 32'h0000_0400, 4'h0, 4'd2, 2,    0,   32'h0000_0004, 32'd4,  4, 32'hF000_0010};
      vecs[6] = '{1'b1, 32'h0000_0FFF, 32'hA5A5_0F0F, 4'h9, 4'd5, 0,    -1,  32'h0000_03FF, 32'd1,  1, 32'h0000_0FFC};
      rv      = '{1'b0, 32'h0000_0100, 32'h0000_0500, 4'h0, 4'd2, 0,    -1,  32'h0000_0040, 32'd4,  4, 32'h0000_0100};

      // Reset state.
      repeat (2) @(negedge sdram_clk);
      check_zero_outputs("reset");
      sdram_rst_n = 1'b1;
      repeat (2) @(negedge sdram_clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Spurious read data while idle.
      ack0 = ack_cnt;
      avl_rdata_valid = 1'b1;
      avl_rdata       = 32'hBAD0_BAD0;
      @(negedge sdram_clk);
      avl_rdata_valid = 1'b0;
      repeat (2) @(negedge sdram_clk);
      check32("spurious_no_ack", 32'(ack_cnt - ack0), 32'h0);
      check32("spurious_no_req", 32'({avl_read_req, avl_write_req}), 32'h0);

      // Read of 8 words, reset after the third ack.
      ack0 = ack_cnt;
      start_access('{1'b0, 32'h0000_0080, 32'h0000_0600, 4'h0, 4'd3, 0, -1,
                     32'h0000_0020, 32'd8, 8, 32'h0000_0080});
      wait_req(1'b1, ok);
      check32("rst_seq_address", 32'(avl_address), 32'h0000_0020);
      avl_ready = 1'b1;
      @(negedge sdram_clk);
      avl_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         avl_rdata_valid = 1'b1;
         avl_rdata       = 32'h600 + 32'(i);
         sb.push_back('{cyc + 1, 32'h80 + 32'(4 * i), 32'h600 + 32'(i), 1'b1});
         @(negedge sdram_clk);
      end
      avl_rdata_valid = 1'b0;
      check32("rst_seq_acks", 32'(ack_cnt - ack0), 32'd3);
      #1;
      sdram_rst_n = 1'b0;
      acc_i       = 1'b0;
      #1;
      check_zero_outputs("midburst_rst");
      ack0 = ack_cnt;
      avl_rdata_valid = 1'b1;
      avl_rdata       = 32'h0000_0DEA;
      repeat (3) @(negedge sdram_clk);
      sdram_rst_n = 1'b1;
      repeat (2) @(negedge sdram_clk);
      avl_rdata_valid = 1'b0;
      repeat (2) @(negedge sdram_clk);
      check32("late_rdata_no_ack", 32'(ack_cnt - ack0), 32'h0);
      check32("late_rdata_no_req", 32'({avl_read_req, avl_write_req}), 32'h0);
      check32("rst_sb_empty", 32'(sb.size()), 32'h0);

      // A normal read after reset.
      run_vec(rv, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
